// File: rtl/udp_echo_engine.sv
// UDP echo engine: decodes the first beat of each Ethernet frame and then
// either forwards the frame or drops it. A matching IPv4/UDP frame is sent
// back with its MAC addresses, IP addresses and UDP ports swapped and its UDP
// checksum cleared. All egress leaves through one registered output stage.
module udp_echo_engine #(
  parameter int          DATA_W      = 512,
  parameter logic [15:0] LISTEN_PORT = 16'd0,
  parameter int          CNT_W       = 32
) (
  input  logic                axis_clk,
  input  logic                axis_rstn,
  input  logic                s_axis_rx_tvalid,
  input  logic [DATA_W-1:0]   s_axis_rx_tdata,
  input  logic [DATA_W/8-1:0] s_axis_rx_tkeep,
  input  logic                s_axis_rx_tlast,
  output logic                s_axis_rx_tready,
  output logic                m_axis_tx_tvalid,
  output logic [DATA_W-1:0]   m_axis_tx_tdata,
  output logic [DATA_W/8-1:0] m_axis_tx_tkeep,
  output logic                m_axis_tx_tlast,
  input  logic                m_axis_tx_tready,
  input  logic                cfg_bypass,
  output logic [CNT_W-1:0]    stat_rx_frames,
  output logic [CNT_W-1:0]    stat_tx_frames,
  output logic [CNT_W-1:0]    stat_drop_frames
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t            state;
  logic              run;
  logic              rx_accept;
  logic              first_beat;
  logic              hdr_match;
  logic              forward;
  logic              pass_beat;
  logic              out_load;
  logic [15:0]       ether_type;
  logic [15:0]       dst_port;
  logic [DATA_W-1:0] echo_data;
  logic [DATA_W-1:0] next_data;

  // Header fields are big-endian across bytes; byte n lives at tdata[8n+:8].
  assign ether_type = {s_axis_rx_tdata[12*8 +: 8], s_axis_rx_tdata[13*8 +: 8]};
  assign dst_port   = {s_axis_rx_tdata[36*8 +: 8], s_axis_rx_tdata[37*8 +: 8]};

  assign hdr_match = (ether_type == 16'h0800) &&
                     (s_axis_rx_tdata[14*8 +: 8] == 8'h45) &&
                     (s_axis_rx_tdata[23*8 +: 8] == 8'd17) &&
                     s_axis_rx_tkeep[41] &&
                     ((LISTEN_PORT == 16'd0) || (dst_port == LISTEN_PORT));

  assign forward    = cfg_bypass || hdr_match;
  assign first_beat = (state == IDLE);
  assign pass_beat  = (state == FWD) || (first_beat && forward);
  assign out_load   = !m_axis_tx_tvalid || m_axis_tx_tready;

  // DROP sinks beats without touching egress, so it never backpressures.
  assign s_axis_rx_tready = run && ((state == DROP) || out_load);
  assign rx_accept        = s_axis_rx_tvalid && s_axis_rx_tready;

  // Build the echoed first beat; the IP checksum is left alone on purpose.
  always_comb begin
    echo_data              = s_axis_rx_tdata;
    echo_data[0*8  +: 48]  = s_axis_rx_tdata[6*8  +: 48];
    echo_data[6*8  +: 48]  = s_axis_rx_tdata[0*8  +: 48];
    echo_data[26*8 +: 32]  = s_axis_rx_tdata[30*8 +: 32];
    echo_data[30*8 +: 32]  = s_axis_rx_tdata[26*8 +: 32];
    echo_data[34*8 +: 16]  = s_axis_rx_tdata[36*8 +: 16];
    echo_data[36*8 +: 16]  = s_axis_rx_tdata[34*8 +: 16];
    echo_data[40*8 +: 16]  = 16'h0000;
    next_data = (first_beat && hdr_match && !cfg_bypass) ? echo_data : s_axis_rx_tdata;
  end

  // Hold ingress ready low from reset until the first clock after release.
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) run <= 1'b0;
    else            run <= 1'b1;
  end

  // Frame state: the forward/drop decision is taken once on the first beat.
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state <= IDLE;
    end else if (rx_accept) begin
      case (state)
        IDLE:    if (!s_axis_rx_tlast) state <= forward ? FWD : DROP;
        FWD:     if (s_axis_rx_tlast) state <= IDLE;
        DROP:    if (s_axis_rx_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Single egress register; it only loads when empty or being drained.
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tkeep  <= '0;
      m_axis_tx_tlast  <= 1'b0;
    end else if (out_load) begin
      m_axis_tx_tvalid <= rx_accept && pass_beat;
      if (rx_accept && pass_beat) begin
        m_axis_tx_tdata <= next_data;
        m_axis_tx_tkeep <= s_axis_rx_tkeep;
        m_axis_tx_tlast <= s_axis_rx_tlast;
      end
    end
  end

  // Saturating frame statistics, counted on accepted first beats only.
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      stat_rx_frames   <= '0;
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
    end else if (rx_accept && first_beat) begin
      if (stat_rx_frames != CNT_MAX) stat_rx_frames <= stat_rx_frames + CNT_ONE;
      if (forward) begin
        if (stat_tx_frames != CNT_MAX) stat_tx_frames <= stat_tx_frames + CNT_ONE;
      end else begin
        if (stat_drop_frames != CNT_MAX) stat_drop_frames <= stat_drop_frames + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/udp_echo_engine.md
UDP_ECHO_ENGINE -- requirements
Module: udp_echo_engine

Interface
REQ-001 Parameter DATA_W, default 512: AXIS data width in bits; SHALL be a multiple of 64 and at least 384.
REQ-002 Parameter LISTEN_PORT, default 16'd0: UDP destination port to echo; 0 means any port.
REQ-003 Parameter CNT_W, default 32: width of the statistics counters.
REQ-004 axis_clk  in  1  the single clock; all logic is rising-edge on it.
REQ-005 axis_rstn  in  1  asynchronous active-low reset.
REQ-006 s_axis_rx_tvalid / tdata / tkeep / tlast  in  1 / DATA_W / DATA_W/8 / 1  ingress Ethernet frame stream.
REQ-007 s_axis_rx_tready  out  1  ingress ready.
REQ-008 m_axis_tx_tvalid / tdata / tkeep / tlast  out  1 / DATA_W / DATA_W/8 / 1  egress stream.
REQ-009 m_axis_tx_tready  in  1  egress ready.
REQ-010 cfg_bypass  in  1  1 = forward all frames unmodified; sampled only at frame start.
REQ-011 stat_rx_frames, stat_tx_frames, stat_drop_frames  out  CNT_W each  saturating frame counters.

Function
REQ-012 Byte n of a beat SHALL be tdata[8n+7:8n]; byte 0 is the first wire byte; multi-byte fields are big-endian across bytes.
REQ-013 The header SHALL be decoded from the first beat only: EtherType bytes 12-13, IP ver/IHL byte 14, protocol byte 23, src IP 26-29, dst IP 30-33, UDP src port 34-35, dst port 36-37, UDP checksum 40-41.
REQ-014 A frame matches if EtherType==0x0800, byte14==0x45, protocol==17, first-beat tkeep[41]==1, and (LISTEN_PORT==0 or dst port==LISTEN_PORT).
REQ-015 State machine states: IDLE (awaiting first beat), FWD (passing remaining beats), DROP (discarding remaining beats).
REQ-016 IDLE: on an accepted first beat with tlast=0, go to FWD if forwarded or DROP if not; with tlast=1, stay in IDLE.
REQ-017 FWD/DROP: return to IDLE on the accepted beat with tlast=1.
REQ-018 Forward decision: forward if cfg_bypass==1 or the frame matches; otherwise drop.
REQ-019 Echo rewrite on a matched frame with cfg_bypass==0: swap dst/src MAC, swap src/dst IP, swap UDP ports, set UDP checksum bytes 40-41 to 0x0000.
REQ-020 The echo rewrite SHALL leave all other bytes, including the IP checksum, unchanged.
REQ-021 Bypass frames and non-first beats SHALL pass with tdata, tkeep and tlast unchanged.
REQ-022 Egress SHALL be one registered output stage; latency is 1 cycle from ingress acceptance to m_axis_tx_tvalid.
REQ-023 In IDLE and FWD, s_axis_rx_tready = !m_axis_tx_tvalid || m_axis_tx_tready.
REQ-024 A first beat that will be dropped SHALL also obey REQ-023, because the decision is made in the same cycle.
REQ-025 In DROP, s_axis_rx_tready SHALL be 1 and no beat SHALL reach egress.
REQ-026 m_axis_tx_tvalid SHALL stay high with stable tdata, tkeep and tlast until m_axis_tx_tready is high; back-to-back beats sustain one beat per cycle.
REQ-027 stat_rx_frames SHALL increment on every accepted first beat.
REQ-028 stat_tx_frames SHALL increment on every forwarded first beat.
REQ-029 stat_drop_frames SHALL increment on every dropped first beat.
REQ-030 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 A cfg_bypass change mid-frame SHALL take effect at the next frame start.

Reset
REQ-032 While axis_rstn is low: state = IDLE, m_axis_tx_tvalid = 0, m_axis_tx_tlast = 0, m_axis_tx_tdata = 0, m_axis_tx_tkeep = 0, all counters = 0, s_axis_rx_tready = 0.
REQ-033 Reset mid-frame SHALL discard the partial frame.
REQ-034 After reset release, the first accepted beat SHALL be treated as a frame start.

Verification
REQ-035 Single-beat UDP frame, dst port 5000, LISTEN_PORT=5000, m_tready=1 -> one cycle later, MACs, IPs and ports are swapped, bytes 40-41=0x0000, rx=1, tx=1, drop=0.
REQ-036 Three-beat ARP frame (EtherType 0x0806) -> no egress beats, s_tready high for beats 2-3, drop=1.
REQ-037 Four-beat matched frame with m_tready toggling 1,0,0,1... -> egress beats are identical and in order, no beat is lost or duplicated, only beat 1 is modified, tkeep and tlast are preserved.
REQ-038 cfg_bypass=1 with a matched frame -> egress is bit-identical to ingress, tx increments.
REQ-039 Runt first beat, tlast=1 and tkeep=0x000...0FF (8 bytes) -> dropped, drop=1.
REQ-040 axis_rstn asserted during beat 2 of a 4-beat frame, then released, then a valid frame sent -> outputs and counters are 0 during reset, and the new frame is echoed correctly.
